// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: PC block control, instruction-memory read port and the
// downstream valid/ready instruction channel, bundled with master/slave views.
interface instr_fetch_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned IW = 8
);
    logic [AW-1:0] pc_count;
    logic          pc_en;
    logic          pc_load;
    logic [AW-1:0] pc_data;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_out;
    logic          halted;
    logic          zero_flag;

    // The fetch unit is the master; the PC block, memory and consumer are the slave side.
    modport master (
        input  pc_count, mem_rdata, instr_ready, zero_flag,
        output pc_en, pc_load, pc_data, mem_addr, instr_valid, instr_out, halted
    );

    modport slave (
        output pc_count, mem_rdata, instr_ready, zero_flag,
        input  pc_en, pc_load, pc_data, mem_addr, instr_valid, instr_out, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: ADDR -> DATA -> ISSUE, with JMP/HLT decode in DATA.
// Optional feature macro: BRANCH_ZERO_EN enables the JZ (3'b101) conditional jump.
module instr_fetch #(
    parameter int unsigned AW = 5,
    parameter int unsigned IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int unsigned OPW = 3;
    localparam logic [OPW-1:0] OP_JZ  = 3'b101;
    localparam logic [OPW-1:0] OP_JMP = 3'b110;
    localparam logic [OPW-1:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        ADDR  = 2'd0,
        DATA  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          pc_en_c;
    logic          pc_load_c;
    logic [AW-1:0] pc_data_c;
    logic [OPW-1:0] opcode;
    logic [AW-1:0]  operand;

    assign opcode  = bus.mem_rdata[IW-1 -: OPW];
    assign operand = bus.mem_rdata[AW-1:0];

`ifndef BRANCH_ZERO_EN
    logic unused_zero_flag;
    assign unused_zero_flag = bus.zero_flag;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ADDR;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // PC control is a decode of the word arriving in DATA, so it is only ever live in DATA.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_en_c   = 1'b0;
        pc_load_c = 1'b0;
        pc_data_c = '0;
        unique case (state_q)
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                ir_d = bus.mem_rdata;
                case (opcode)
                    OP_JMP: begin
                        pc_load_c = 1'b1;
                        pc_data_c = operand;
                        state_d   = ADDR;
                    end
                    OP_HLT: begin
                        state_d = HALT;
                    end
`ifdef BRANCH_ZERO_EN
                    OP_JZ: begin
                        if (bus.zero_flag) begin
                            pc_load_c = 1'b1;
                            pc_data_c = operand;
                        end else begin
                            pc_en_c = 1'b1;
                        end
                        state_d = ADDR;
                    end
`endif
                    default: begin
                        pc_en_c = 1'b1;
                        state_d = ISSUE;
                    end
                endcase
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    state_d = ADDR;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = ADDR;
            end
        endcase
        // Keep the PC block quiet while reset is being applied.
        if (rst) begin
            pc_en_c   = 1'b0;
            pc_load_c = 1'b0;
            pc_data_c = '0;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.pc_load     = pc_load_c;
    assign bus.pc_data     = pc_data_c;
    assign bus.mem_addr    = bus.pc_count;
    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.instr_out   = ir_q;
    assign bus.halted      = (state_q == HALT);

    a_pc_ctrl_excl: assert property (@(posedge clk) disable iff (rst)
        !(pc_en_c && pc_load_c));
    a_pc_ctrl_data_only: assert property (@(posedge clk) disable iff (rst)
        (pc_en_c || pc_load_c) |-> (state_q == DATA));
    a_halt_sticky: assert property (@(posedge clk) disable iff (rst)
        (state_q == HALT) |=> (state_q == HALT));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC block and synchronous memory models, a program-level
// reference walker, a per-cycle compare process and directed reset/stall/halt phases.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.AW(5), .IW(8)) bus ();
    instr_fetch #(.AW(5), .IW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef BRANCH_ZERO_EN
    localparam bit BZ_EN = 1'b1;
`else
    localparam bit BZ_EN = 1'b0;
`endif

    logic [7:0] mem [32];
    logic [4:0] pc_q;

    // Environment: PC block and synchronous-read instruction memory.
    always @(posedge clk) begin
        if (rst)              pc_q <= 5'd0;
        else if (bus.pc_load) pc_q <= bus.pc_data;
        else if (bus.pc_en)   pc_q <= pc_q + 5'd1;
        bus.mem_rdata <= mem[bus.mem_addr];
    end
    assign bus.pc_count = pc_q;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    // Reference: walk the program by instruction semantics.
    logic [7:0] exp_q[$];
    logic [4:0] exp_load_q[$];
    int         exp_pc_en;

    task automatic build_model(input logic zf);
        logic [4:0] pc;
        logic [7:0] w;
        pc = 5'd0;
        exp_q.delete();
        exp_load_q.delete();
        exp_pc_en = 0;
        for (int s = 0; s < 64; s++) begin
            w = mem[pc];
            if (w[7:5] == 3'b110) begin
                exp_load_q.push_back(w[4:0]);
                pc = w[4:0];
            end else if (w[7:5] == 3'b111) begin
                break;
            end else if (BZ_EN && w[7:5] == 3'b101) begin
                if (zf) begin
                    exp_load_q.push_back(w[4:0]);
                    pc = w[4:0];
                end else begin
                    exp_pc_en++;
                    pc = pc + 5'd1;
                end
            end else begin
                exp_q.push_back(w);
                exp_pc_en++;
                pc = pc + 5'd1;
            end
        end
    endtask

    // Per-cycle compare against the reference and the interface rules.
    logic       pv, pr, pl;
    logic [7:0] po;
    logic [4:0] pd;
    int         pc_en_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pl = 1'b0;
        end else begin
            check("pc_ctrl_exclusive", 32'(bus.pc_en && bus.pc_load), 32'd0);
            check("mem_addr_eq_pc", 32'(bus.mem_addr), 32'(bus.pc_count));
            if (!bus.pc_load) check("pc_data_idle", 32'(bus.pc_data), 32'd0);
            if (bus.halted)
                check("halt_quiet", 32'({bus.instr_valid, bus.pc_en, bus.pc_load}), 32'd0);
            if (pv && !pr)
                check("stall_hold", 32'({bus.instr_valid, bus.instr_out, bus.pc_en, bus.pc_load}),
                      32'({1'b1, po, 2'b00}));
            if (pl) check("load_target", 32'(bus.mem_addr), 32'(pd));
            if (bus.pc_en) pc_en_seen++;
            if (bus.pc_load) begin
                if (exp_load_q.size() == 0) fail_now("load_extra");
                else check("load_data", 32'(bus.pc_data), 32'(exp_load_q.pop_front()));
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) fail_now("issue_extra");
                else check("issue_word", 32'(bus.instr_out), 32'(exp_q.pop_front()));
            end
            pv = bus.instr_valid;
            pr = bus.instr_ready;
            po = bus.instr_out;
            pl = bus.pc_load;
            pd = bus.pc_data;
        end
    end

    int acc[$];
    int cyc;
    int vcount;
    bit stalled;

    initial begin
        rst             = 1'b1;
        bus.instr_ready = 1'b1;
        bus.zero_flag   = 1'b1;
        stalled         = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
        mem[0]  = 8'h01;
        mem[1]  = 8'h22;
        mem[2]  = 8'hCA;
        mem[7]  = 8'h44;
        mem[8]  = 8'hE0;
        mem[10] = 8'hA7;
        mem[11] = 8'h44;
        mem[12] = 8'hE0;

        build_model(1'b1);
        // Hand-derived program outcome pins the walker.
`ifdef BRANCH_ZERO_EN
        check("model_len", 32'(exp_q.size()), 32'd3);
        check("model_w2", 32'(exp_q[2]), 32'h44);
        check("model_loads", 32'(exp_load_q.size()), 32'd2);
        check("model_pc_en", 32'(exp_pc_en), 32'd3);
`else
        check("model_len", 32'(exp_q.size()), 32'd4);
        check("model_w2", 32'(exp_q[2]), 32'hA7);
        check("model_loads", 32'(exp_load_q.size()), 32'd1);
        check("model_pc_en", 32'(exp_pc_en), 32'd4);
`endif
        check("model_load0", 32'(exp_load_q[0]), 32'd10);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_pc_en", 32'(bus.pc_en), 32'd0);
        check("rst_pc_load", 32'(bus.pc_load), 32'd0);
        check("rst_pc_data", 32'(bus.pc_data), 32'd0);
        check("rst_ir", 32'(bus.instr_out), 32'd0);

        rst = 1'b0;
        cyc = 0;
        while (!bus.halted && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.instr_valid && bus.instr_out == 8'h44 && !stalled) begin
                stalled         = 1'b1;
                bus.instr_ready = 1'b0;
                vcount          = 1;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (bus.instr_valid && bus.instr_out == 8'h44) vcount++;
                end
                bus.instr_ready = 1'b1;
                check("stall_valid_cycles", 32'(vcount), 32'd5);
                acc.push_back(cyc);
                @(posedge clk);
                #1;
                cyc++;
                check("post_stall_addr", 32'({bus.instr_valid, bus.pc_en, bus.pc_load}), 32'd0);
            end else if (bus.instr_valid && bus.instr_ready) begin
                acc.push_back(cyc);
            end
        end
        if (!bus.halted) fail_now("halt_timeout");

        if (acc.size() < 2) fail_now("accept_count");
        else begin
            check("first_latency", 32'(acc[0]), 32'd2);
            check("throughput_gap", 32'(acc[1] - acc[0]), 32'd3);
        end
        check("all_issued", 32'(exp_q.size()), 32'd0);
        check("all_loads", 32'(exp_load_q.size()), 32'd0);
        check("pc_en_count", 32'(pc_en_seen), 32'(exp_pc_en));
        check("stall_exercised", 32'(stalled), 32'd1);

        // Nothing but reset may leave HALT.
        repeat (20) begin
            @(posedge clk);
            #1;
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.zero_flag   = 1'($urandom_range(0, 1));
            check("halt_sticky", 32'(bus.halted), 32'd1);
        end
        bus.instr_ready = 1'b0;
        bus.zero_flag   = 1'b1;

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("unhalt_halted", 32'(bus.halted), 32'd0);
        check("unhalt_addr", 32'({bus.instr_valid, bus.pc_en, bus.pc_load}), 32'd0);
        build_model(1'b1);

        cyc = 0;
        while (!bus.instr_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.instr_valid) fail_now("refetch_timeout");
        else begin
            check("refetch_latency", 32'(cyc), 32'd2);
            check("refetch_word", 32'(bus.instr_out), 32'h01);
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_issue_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_issue_ir", 32'(bus.instr_out), 32'd0);
        rst             = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
